load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
// - Data-side LSU: serves the core's lsu_en/lsu_done handshake and drives the data-memory bus.
// - Issues byte/half/word loads and stores; splits misaligned accesses into two word transactions.
// - Aligns and sign/zero-extends load data.
// - Sits between the decode/execute stage (which holds lsu_en_i until lsu_done_o) and the data RAM/interconnect.
// PARAMETERS
// ADDR_WIDTH       32  byte-address width of lsu_addr_i / data_addr_o
// SPLIT_MISALIGNED 1   1: misaligned access = two bus transactions; 0: misaligned -> error, no bus activity
// PORTS
// clk            in   1           clock, all state on rising edge
// rst_n          in   1           asynchronous reset, active low
// lsu_en_i       in   1           access request, held high until lsu_done_o
// lsu_we_i       in   1           1 = store, 0 = load
// lsu_type_i     in   2           00 byte, 01 half, 10 word, 11 reserved (treated as word)
// lsu_sign_ext_i in   1           loads: 1 sign-extend, 0 zero-extend
// lsu_addr_i     in   ADDR_WIDTH  byte address
// lsu_wdata_i    in   32          store data, LSB-aligned
// lsu_done_o     out  1           one-cycle completion pulse
// lsu_rdata_o    out  32          extended load result, valid from the done cycle
// lsu_err_o      out  1           misaligned access with SPLIT_MISALIGNED=0; valid with done
// data_req_o     out  1           bus request, held until data_gnt_i
// data_gnt_i     in   1           bus grant; address phase completes on req & gnt
// data_rvalid_i  in   1           response (reads and writes), >=1 cycle after grant
// data_addr_o    out  ADDR_WIDTH  word-aligned bus address, addr[1:0] = 0
// data_we_o      out  1           bus write enable
// data_be_o      out  4           byte enables
// data_wdata_o   out  32          rotated store data
// data_rdata_i   in   32          read data, valid with data_rvalid_i
// BEHAVIOUR
// - Reset values: all outputs 0; state IDLE; phase 0.
// - All outputs are registered.
// - States: IDLE, REQ, WAIT, DONE.
// - Phase bit: 0 = first transaction, 1 = second transaction.
// - IDLE:
//   - On lsu_en_i, capture we/type/sign/addr/wdata.
//   - off = addr[1:0]; mis = (half & off==3) | (word & off!=0).
//   - mis & !SPLIT_MISALIGNED: go DONE with err=1.
//   - Otherwise go REQ, phase 0.
// - REQ:
//   - data_req_o=1; addr = {addr[AW-1:2],2'b00} + 4*phase.
//   - Go WAIT on data_gnt_i. req/addr/we/be/wdata stay stable until grant.
// - WAIT:
//   - data_req_o=0. On data_rvalid_i, capture data_rdata_i.
//   - If mis & phase==0: phase<=1, go REQ.
//   - Otherwise go DONE.
// - DONE:
//   - lsu_done_o=1 for exactly this cycle; go IDLE.
//   - lsu_en_i is ignored in DONE; a new access is accepted only in the following IDLE cycle.
// - Minimum latency, aligned access, gnt in REQ cycle, rvalid the next cycle:
//   - en seen in cycle 0, req in cycle 1, rvalid in cycle 2, done in cycle 3.
//   - Each split adds 2 cycles.
// - Byte enables and write data:
//   - base_be = 0001 / 0011 / 1111 for byte / half / word.
//   - be9 = base_be << off (8 bits). Phase 0 be = be9[3:0]; phase 1 be = be9[7:4].
//   - data_wdata_o = wdata rotated left by 8*off in both phases.
// - Load assembly:
//   - lo = rdata0 >> 8*off.
//   - For split accesses, raw = lo | (rdata1 << 8*(4-off)); otherwise raw = lo.
//   - Result = raw[7:0], raw[15:0] or raw[31:0], extended per lsu_sign_ext_i.
//   - lsu_rdata_o updates only on the done of a load and holds otherwise.
// - Stores: lsu_rdata_o unchanged; data_rvalid_i still required before done.
// - lsu_en_i falling mid-access: ignored; the bus transaction completes and done still pulses.
// - data_rvalid_i in IDLE/REQ/DONE (stray, or after reset mid-access): ignored.
// - Reset mid-access: immediate IDLE with data_req_o=0. No completion for the aborted access.
// - lsu_err_o is 0 on every non-error done and holds its value otherwise.
// TESTING
// - Aligned LW 0x100, gnt immediate, rvalid next cycle, rdata 0xDEADBEEF
//   -> req 1 cycle at 0x100, be 1111; done at cycle 3; rdata 0xDEADBEEF.
// - LB sign 0x103, rdata 0x80FF_0000 -> be 1000; lsu_rdata_o 0xFFFFFF80.
//   Same with sign_ext=0 -> 0x00000080.
// - SW 0x11223344 to 0x102, SPLIT=1
//   -> txn1 addr 0x100, be 1100, wdata 0x33441122; txn2 addr 0x104, be 0011, same wdata; one done.
// - LW 0x101, rdata0 0xAABBCCDD, rdata1 0x11223344 -> lsu_rdata_o 0x44AABBCC.
//   With SPLIT=0 -> no req; done cycle 1 after en, err=1.
// - gnt delayed 3 cycles, rvalid 2 cycles after gnt
//   -> req/addr/be stable until gnt; single done pulse; stray rvalid in IDLE ignored.
// - rst_n low in WAIT, then rvalid arrives -> outputs 0, no done.
//   Next LW after reset completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// Data-side load/store unit. It serves the core's lsu_en/lsu_done handshake and drives a req/gnt/rvalid data bus.
// Misaligned accesses either become two word transactions or are rejected with an error, selected by SPLIT_MISALIGNED.
module load_store_unit #(
    parameter int ADDR_WIDTH       = 32,
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  lsu_en_i,
    input  logic                  lsu_we_i,
    input  logic [1:0]            lsu_type_i,
    input  logic                  lsu_sign_ext_i,
    input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
    input  logic [31:0]           lsu_wdata_i,
    output logic                  lsu_done_o,
    output logic [31:0]           lsu_rdata_o,
    output logic                  lsu_err_o,
    output logic                  data_req_o,
    input  logic                  data_gnt_i,
    input  logic                  data_rvalid_i,
    output logic [ADDR_WIDTH-1:0] data_addr_o,
    output logic                  data_we_o,
    output logic [3:0]            data_be_o,
    output logic [31:0]           data_wdata_o,
    input  logic [31:0]           data_rdata_i
);

    // state | meaning
    // IDLE  | waiting for lsu_en_i
    // REQ   | bus request held until grant
    // WAIT  | granted, waiting for rvalid
    // DONE  | one-cycle completion pulse
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t state_q, state_d;
    logic   phase_q, phase_d;

    logic                  we_q, sign_q, mis_q;
    logic [1:0]            type_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           rdata0_q, rdata0_d;
    logic                  capture;
    logic                  mis_in;

    logic                  req_d, we_d, done_d, err_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [3:0]            be_d;
    logic [31:0]           wdata_d, rdata_d;

    function automatic logic is_mis(input logic [1:0] typ, input logic [1:0] off);
        return ((typ == 2'b01) && (off == 2'b11)) || (typ[1] && (off != 2'b00));
    endfunction

    // Byte enables of both bus words packed into 8 bits; phase selects the half.
    function automatic logic [3:0] lane_be(input logic [1:0] typ, input logic [1:0] off,
                                           input logic ph);
        logic [7:0] be9;
        case (typ)
            2'b00:   be9 = 8'b0000_0001;
            2'b01:   be9 = 8'b0000_0011;
            default: be9 = 8'b0000_1111;
        endcase
        be9 = be9 << off;
        return ph ? be9[7:4] : be9[3:0];
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] d, input logic [1:0] off);
        logic [63:0] dd;
        dd = {d, d} << {off, 3'b000};
        return dd[63:32];
    endfunction

    function automatic logic [31:0] load_result(input logic [31:0] first, input logic [31:0] second,
                                                input logic split, input logic [1:0] off,
                                                input logic [1:0] typ, input logic sign);
        logic [31:0] raw;
        raw = first >> {off, 3'b000};
        if (split) begin
            raw = raw | (second << (6'd32 - {1'b0, off, 3'b000}));
        end
        case (typ)
            2'b00:   return {{24{sign & raw[7]}}, raw[7:0]};
            2'b01:   return {{16{sign & raw[15]}}, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    assign mis_in = is_mis(lsu_type_i, lsu_addr_i[1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            phase_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        rdata0_d = rdata0_q;
        capture  = 1'b0;
        req_d    = data_req_o;
        addr_d   = data_addr_o;
        we_d     = data_we_o;
        be_d     = data_be_o;
        wdata_d  = data_wdata_o;
        done_d   = 1'b0;
        rdata_d  = lsu_rdata_o;
        err_d    = lsu_err_o;
        case (state_q)
            IDLE: begin
                if (lsu_en_i) begin
                    capture = 1'b1;
                    if (mis_in && !SPLIT_MISALIGNED) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = REQ;
                        phase_d = 1'b0;
                        req_d   = 1'b1;
                        addr_d  = {lsu_addr_i[ADDR_WIDTH-1:2], 2'b00};
                        we_d    = lsu_we_i;
                        be_d    = lane_be(lsu_type_i, lsu_addr_i[1:0], 1'b0);
                        wdata_d = rotl(lsu_wdata_i, lsu_addr_i[1:0]);
                    end
                end
            end
            REQ: begin
                if (data_gnt_i) begin
                    state_d = WAIT;
                    req_d   = 1'b0;
                end
            end
            WAIT: begin
                if (data_rvalid_i) begin
                    if (mis_q && !phase_q) begin
                        rdata0_d = data_rdata_i;
                        phase_d  = 1'b1;
                        state_d  = REQ;
                        req_d    = 1'b1;
                        addr_d   = {addr_q[ADDR_WIDTH-1:2], 2'b00} + ADDR_WIDTH'(4);
                        be_d     = lane_be(type_q, addr_q[1:0], 1'b1);
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b0;
                        if (!we_q) begin
                            // After a split the first word sits in rdata0_q and the second is on the bus now.
                            rdata_d = load_result(mis_q ? rdata0_q : data_rdata_i, data_rdata_i,
                                                  mis_q, addr_q[1:0], type_q, sign_q);
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q         <= 1'b0;
            sign_q       <= 1'b0;
            mis_q        <= 1'b0;
            type_q       <= 2'b00;
            addr_q       <= '0;
            rdata0_q     <= '0;
            data_req_o   <= 1'b0;
            data_addr_o  <= '0;
            data_we_o    <= 1'b0;
            data_be_o    <= 4'b0000;
            data_wdata_o <= '0;
            lsu_done_o   <= 1'b0;
            lsu_rdata_o  <= '0;
            lsu_err_o    <= 1'b0;
        end else begin
            if (capture) begin
                we_q   <= lsu_we_i;
                sign_q <= lsu_sign_ext_i;
                mis_q  <= mis_in;
                type_q <= lsu_type_i;
                addr_q <= lsu_addr_i;
            end
            rdata0_q     <= rdata0_d;
            data_req_o   <= req_d;
            data_addr_o  <= addr_d;
            data_we_o    <= we_d;
            data_be_o    <= be_d;
            data_wdata_o <= wdata_d;
            lsu_done_o   <= done_d;
            lsu_rdata_o  <= rdata_d;
            lsu_err_o    <= err_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed and random accesses checked against a byte-addressed memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lsu_en, lsu_we, lsu_sign;
    logic [1:0]  lsu_type;
    logic [31:0] lsu_addr, lsu_wdata;
    logic        lsu_done, lsu_err;
    logic [31:0] lsu_rdata;
    logic        data_req, data_gnt, data_rvalid, data_we;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_be;

    // Second instance without splitting; shares the request fields, own handshake and bus.
    logic        en0, gnt0, rvalid0;
    logic        done0, err0, req0, we0;
    logic [31:0] rdata_s0, addr0, wdata0;
    logic [3:0]  be0;

    int tests = 0;
    int fails = 0;
    logic [7:0]  mem [0:1023];
    logic [31:0] exp_rdata = '0;
    logic [31:0] exp_rdata0 = '0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_WIDTH(32), .SPLIT_MISALIGNED(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .lsu_en_i(lsu_en), .lsu_we_i(lsu_we), .lsu_type_i(lsu_type), .lsu_sign_ext_i(lsu_sign),
        .lsu_addr_i(lsu_addr), .lsu_wdata_i(lsu_wdata),
        .lsu_done_o(lsu_done), .lsu_rdata_o(lsu_rdata), .lsu_err_o(lsu_err),
        .data_req_o(data_req), .data_gnt_i(data_gnt), .data_rvalid_i(data_rvalid),
        .data_addr_o(data_addr), .data_we_o(data_we), .data_be_o(data_be),
        .data_wdata_o(data_wdata), .data_rdata_i(data_rdata)
    );

    load_store_unit #(.ADDR_WIDTH(32), .SPLIT_MISALIGNED(1'b0)) dut_nosplit (
        .clk(clk), .rst_n(rst_n),
        .lsu_en_i(en0), .lsu_we_i(lsu_we), .lsu_type_i(lsu_type), .lsu_sign_ext_i(lsu_sign),
        .lsu_addr_i(lsu_addr), .lsu_wdata_i(lsu_wdata),
        .lsu_done_o(done0), .lsu_rdata_o(rdata_s0), .lsu_err_o(err0),
        .data_req_o(req0), .data_gnt_i(gnt0), .data_rvalid_i(rvalid0),
        .data_addr_o(addr0), .data_we_o(we0), .data_be_o(be0),
        .data_wdata_o(wdata0), .data_rdata_i(data_rdata)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] b;
        b = a & 32'h3FC;
        return {mem[b + 3], mem[b + 2], mem[b + 1], mem[b]};
    endfunction

    task automatic set_word(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) mem[((a & 32'h3FC) + 32'(i))] = w[8*i +: 8];
    endtask

    // One access from the core's side, with the bus answered from the memory model.
    task automatic access(input logic we, input logic [1:0] typ, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int gdly, input int rdly, input logic drop_en);
        int          n, ntx, lane;
        logic [31:0] w0, bus_a, exp_wd, val;
        logic [3:0]  exp_be;
        n   = (typ == 2'd0) ? 1 : (typ == 2'd1) ? 2 : 4;
        w0  = addr >> 2;
        ntx = (((addr + 32'(n) - 32'd1) >> 2) != w0) ? 2 : 1;
        exp_wd = '0;
        for (int i = 0; i < 4; i++) begin
            lane = (int'(addr[1:0]) + i) % 4;
            exp_wd[8*lane +: 8] = wd[8*i +: 8];
        end
        val = '0;
        for (int i = 0; i < n; i++) val[8*i +: 8] = mem[(addr + 32'(i)) & 32'h3FF];
        if (sg && n < 4 && val[8*n-1]) begin
            for (int i = n; i < 4; i++) val[8*i +: 8] = 8'hFF;
        end

        lsu_we = we; lsu_type = typ; lsu_sign = sg; lsu_addr = addr; lsu_wdata = wd;
        lsu_en = 1'b1;
        step();
        if (drop_en) lsu_en = 1'b0;
        for (int t = 0; t < ntx; t++) begin
            bus_a  = (w0 + 32'(t)) << 2;
            exp_be = '0;
            for (int i = 0; i < n; i++) begin
                if (((addr + 32'(i)) >> 2) == w0 + 32'(t)) exp_be[int'((addr + 32'(i)) & 32'd3)] = 1'b1;
            end
            for (int g = 0; g <= gdly; g++) begin
                if (g > 0) step();
                check("req", 32'(data_req), 32'd1);
                check("bus_addr", data_addr, bus_a);
                check("bus_be", 32'(data_be), 32'(exp_be));
                check("bus_we", 32'(data_we), 32'(we));
                if (we) check("bus_wdata", data_wdata, exp_wd);
            end
            data_gnt = 1'b1;
            step();
            data_gnt = 1'b0;
            check("req_after_gnt", 32'(data_req), 32'd0);
            for (int r = 1; r < rdly; r++) begin
                step();
                check("early_done", 32'(lsu_done), 32'd0);
            end
            data_rvalid = 1'b1;
            data_rdata  = mem_word(bus_a);
            step();
            data_rvalid = 1'b0;
            data_rdata  = $urandom();
        end
        if (!we) exp_rdata = val;
        else for (int i = 0; i < n; i++) mem[(addr + 32'(i)) & 32'h3FF] = wd[8*i +: 8];
        check("done", 32'(lsu_done), 32'd1);
        check("rdata", lsu_rdata, exp_rdata);
        check("err", 32'(lsu_err), 32'd0);
        lsu_en = 1'b0;
        step();
        check("done_pulse", 32'(lsu_done), 32'd0);
        check("rdata_hold", lsu_rdata, exp_rdata);
    endtask

    task automatic stray();
        data_rvalid = 1'b1;
        data_rdata  = $urandom();
        step();
        data_rvalid = 1'b0;
        step();
        check("stray_done", 32'(lsu_done), 32'd0);
        check("stray_req", 32'(data_req), 32'd0);
        check("stray_rdata", lsu_rdata, exp_rdata);
    endtask

    initial begin
        rst_n = 1'b0;
        lsu_en = 1'b0; lsu_we = 1'b0; lsu_type = 2'd0; lsu_sign = 1'b0;
        lsu_addr = '0; lsu_wdata = '0;
        data_gnt = 1'b0; data_rvalid = 1'b0; data_rdata = '0;
        en0 = 1'b0; gnt0 = 1'b0; rvalid0 = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom());
        step();
        step();
        check("rst_ctl", {26'd0, data_req, data_we, lsu_done, lsu_err, req0, done0}, 32'd0);
        check("rst_bus", {28'd0, data_be}, 32'd0);
        check("rst_addr", data_addr, 32'd0);
        check("rst_rdata", lsu_rdata, 32'd0);
        rst_n = 1'b1;
        step();

        set_word(32'h100, 32'hDEADBEEF);
        access(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0, 1, 1'b0);
        check("lw_value", lsu_rdata, 32'hDEADBEEF);

        set_word(32'h100, 32'h80FF0000);
        access(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 0, 1, 1'b0);
        check("lb_sign", lsu_rdata, 32'hFFFFFF80);
        access(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 0, 1, 1'b0);
        check("lb_zero", lsu_rdata, 32'h00000080);

        access(1'b1, 2'd2, 1'b0, 32'h102, 32'h11223344, 0, 1, 1'b0);
        check("sw_keeps_rdata", lsu_rdata, 32'h00000080);

        set_word(32'h100, 32'hAABBCCDD);
        set_word(32'h104, 32'h11223344);
        access(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 0, 1, 1'b0);
        check("lw_split", lsu_rdata, 32'h44AABBCC);

        access(1'b0, 2'd1, 1'b1, 32'h1FE, 32'h0, 3, 2, 1'b0);
        stray();

        // Reset while waiting for rvalid, then a late rvalid.
        lsu_we = 1'b0; lsu_type = 2'd2; lsu_addr = 32'h200; lsu_en = 1'b1;
        step();
        check("pre_rst_req", 32'(data_req), 32'd1);
        data_gnt = 1'b1;
        step();
        data_gnt = 1'b0;
        lsu_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_mid_ctl", {28'd0, data_req, data_we, lsu_done, lsu_err}, 32'd0);
        check("rst_mid_rdata", lsu_rdata, 32'd0);
        check("rst_mid_addr", data_addr, 32'd0);
        #2;
        rst_n = 1'b1;
        exp_rdata = '0;
        data_rvalid = 1'b1;
        data_rdata = 32'h5A5A5A5A;
        step();
        data_rvalid = 1'b0;
        check("rst_no_done", 32'(lsu_done), 32'd0);
        step();
        check("rst_no_done2", 32'(lsu_done), 32'd0);
        check("rst_no_req", 32'(data_req), 32'd0);
        access(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 0, 1, 1'b0);

        // No-split instance: misaligned word errors without bus activity, aligned load clears err.
        lsu_we = 1'b0; lsu_type = 2'd2; lsu_addr = 32'h101; en0 = 1'b1;
        step();
        check("ns_done", 32'(done0), 32'd1);
        check("ns_err", 32'(err0), 32'd1);
        check("ns_no_req", 32'(req0), 32'd0);
        en0 = 1'b0;
        step();
        check("ns_pulse", 32'(done0), 32'd0);
        check("ns_err_hold", 32'(err0), 32'd1);
        check("ns_rdata_hold", rdata_s0, exp_rdata0);
        lsu_addr = 32'h100; en0 = 1'b1;
        step();
        check("ns_req", 32'(req0), 32'd1);
        check("ns_addr", addr0, 32'h100);
        gnt0 = 1'b1;
        step();
        gnt0 = 1'b0; en0 = 1'b0;
        rvalid0 = 1'b1; data_rdata = 32'h12345678;
        step();
        rvalid0 = 1'b0;
        exp_rdata0 = 32'h12345678;
        check("ns_done2", 32'(done0), 32'd1);
        check("ns_err_clear", 32'(err0), 32'd0);
        check("ns_rdata", rdata_s0, exp_rdata0);
        step();

        for (int k = 0; k < 60; k++) begin
            access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   32'h100 + 32'($urandom_range(0, 511)), $urandom(),
                   int'($urandom_range(0, 3)), int'($urandom_range(1, 3)),
                   1'($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 3) == 0) stray();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
